fir_interp: RTL and testbench

//  Polyphase FIR interpolator: upsamples a 16-bit unsigned sample stream by L.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_mac.sv | 30 +++
 rtl/fir_interp.sv | 123 ++++++++++++
 tb/tb_fir_interp.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and defaults for the polyphase FIR interpolator family.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int L_DEF     = 3;
  localparam int TAPS_DEF  = 9;
  localparam int DW_DEF    = 16;
  localparam int CW_DEF    = 16;
  localparam int SHIFT_DEF = 15;
  localparam int ACC_W_DEF = 36;
  localparam int K         = TAPS_DEF / L_DEF;

  // Linear-interpolation prototype in Q15; every phase sums to 32768.
  localparam logic [CW_DEF-1:0] FIR_INTERP_H0 [0:TAPS_DEF-1] = '{
    16'd0, 16'd10923, 16'd21845, 16'd32768, 16'd21845, 16'd10923, 16'd0, 16'd0, 16'd0
  };

endpackage

// File: rtl/fir_mac.sv
// Time-shared unsigned multiply-accumulate with a registered accumulator.
module fir_mac #(
  parameter int AW    = 16,
  parameter int BW    = 16,
  parameter int ACC_W = 36
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] acc_next
);

  logic [AW+BW-1:0] prod;

  assign prod     = a * b;
  assign acc_next = acc + ACC_W'(prod);

  // acc_next is exposed so the caller can round the final sum in the same cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/fir_interp.sv
// Polyphase FIR interpolator: one input sample yields L output phases through a single MAC.
module fir_interp
  import fir_pkg::*;
#(
  parameter int L     = L_DEF,
  parameter int TAPS  = TAPS_DEF,
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] dout,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          coef_we,
  input  logic [3:0]    coef_addr,
  input  logic [CW-1:0] coef_wdata,
  output logic          busy
);

  localparam int NK = TAPS / L;
  localparam int KW = (NK > 1) ? $clog2(NK) : 1;
  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int RW = ACC_W + 1;

  state_t            state, state_nx;
  logic [KW-1:0]     k;
  logic [PW-1:0]     p;
  logic [IW-1:0]     coef_idx;
  logic [DW-1:0]     dly [0:NK-1];
  logic [CW-1:0]     h   [0:TAPS-1];
  logic [ACC_W-1:0]  acc, acc_next;
  logic              accept, out_fire, last_k, last_p, mac_clr, mac_en;

  // Round half up, then clamp to the unsigned output range.
  function automatic logic [DW-1:0] round_sat(input logic [ACC_W-1:0] a);
    logic [RW-1:0] r;
    r = {1'b0, a} + (RW'(1) << (SHIFT - 1));
    r = r >> SHIFT;
    if (|r[RW-1:DW]) return '1;
    return r[DW-1:0];
  endfunction

  assign accept   = (state == IDLE) && in_valid;
  assign out_fire = (state == OUT) && out_ready;
  assign last_k   = (int'(k) == NK - 1);
  assign last_p   = (int'(p) == L - 1);
  assign mac_clr  = accept || (out_fire && !last_p);
  assign mac_en   = (state == MAC);
  assign coef_idx = IW'(p) + IW'(L) * IW'(k);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = MAC;
      MAC:     if (last_k) state_nx = OUT;
      OUT:     if (out_ready) state_nx = last_p ? IDLE : MAC;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
    busy      = (state != IDLE);
  end

  // Stage: delay line, coefficient store and tap/phase sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NK; i++) dly[i] <= '0;
      for (int i = 0; i < TAPS; i++) h[i] <= FIR_INTERP_H0[i];
      k    <= '0;
      p    <= '0;
      dout <= '0;
    end else begin
      if (accept) begin
        dly[0] <= din;
        for (int i = 1; i < NK; i++) dly[i] <= dly[i-1];
        k <= '0;
        p <= '0;
      end
      if (state == MAC) begin
        k <= last_k ? '0 : k + 1'b1;
        if (last_k) dout <= round_sat(acc_next);
      end
      if (out_fire && !last_p) begin
        p <= p + 1'b1;
        k <= '0;
      end
      // Writes only land between samples so a phase never mixes old and new taps.
      if (state == IDLE && !in_valid && coef_we && int'(coef_addr) < TAPS)
        h[coef_addr] <= coef_wdata;
    end
  end

  // Stage: multiply-accumulate over the K taps of the current phase
  fir_mac #(
    .AW    (CW),
    .BW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .clr      (mac_clr),
    .en       (mac_en),
    .a        (h[coef_idx]),
    .b        (dly[k]),
    .acc      (acc),
    .acc_next (acc_next)
  );

endmodule

// File: tb/tb_fir_interp.sv
// Directed bench for fir_interp: impulse, DC, backpressure, saturation/coef writes, mid-op reset.
module tb_fir_interp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fir_interp dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dout       (dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1; din = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] v);
    int n = 0;
    while (!in_ready && n < 100) begin tick; n++; end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; din = v;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin tick; n++; end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_out_timeout out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1; in_valid = 1'b1; din = 16'd123; coef_we = 1'b0; out_ready = 1'b1;
    tick; tick;
    rst = 1'b0; in_valid = 1'b0;
    vectors += 4;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (dout !== 16'd0) begin miscompares++; $display("FAIL reset_dout got=%0d want=0", dout); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
    send(16'd0);
    vectors += 2;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL accept_busy got=%b want=1", busy); end
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL accept_in_ready got=%b want=0", in_ready); end
    for (int ph = 0; ph < 3; ph++) begin wait_out(n); tick; end
  endtask

  task automatic test_impulse;
    int n;
    int imp [9] = '{0, 10000, 20000, 30000, 20000, 10000, 0, 0, 0};
    do_reset;
    for (int s = 0; s < 3; s++) begin
      send((s == 0) ? 16'd30000 : 16'd0);
      for (int ph = 0; ph < 3; ph++) begin
        wait_out(n);
        vectors++;
        if (dout !== 16'(imp[3*s+ph])) begin
          miscompares++;
          $display("FAIL impulse[%0d] dout=%0d required %0d", 3*s+ph, dout, imp[3*s+ph]);
        end
        if (s == 0 && ph == 0) begin
          vectors++;
          if (n != 3) begin miscompares++; $display("FAIL impulse_latency cycles=%0d required 3", n); end
        end
        tick;
      end
    end
  endtask

  task automatic test_dc;
    int dc0 [3] = '{0, 333, 667};
    int ph;
    do_reset;
    for (int s = 0; s < 5; s++) begin
      send(16'd1000);
      for (int i = 0; i <= 12; i++) begin
        vectors += 2;
        if (in_ready !== (i == 12)) begin
          miscompares++;
          $display("FAIL dc_in_ready s=%0d i=%0d got=%b want=%b", s, i, in_ready, (i == 12));
        end
        if (out_valid !== (i == 3 || i == 7 || i == 11)) begin
          miscompares++;
          $display("FAIL dc_out_valid s=%0d i=%0d got=%b", s, i, out_valid);
        end
        if (i == 3 || i == 7 || i == 11) begin
          ph = (i - 3) / 4;
          vectors++;
          if (dout !== 16'((s == 0) ? dc0[ph] : 1000)) begin
            miscompares++;
            $display("FAIL dc_dout s=%0d ph=%0d got=%0d want=%0d", s, ph, dout, (s == 0) ? dc0[ph] : 1000);
          end
        end
        if (i < 12) tick;
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    int b_exp [3] = '{30000, 20000, 10000};
    do_reset;
    in_valid = 1'b1; din = 16'd30000;
    tick;
    din = 16'd0;
    wait_out(n);
    vectors++;
    if (dout !== 16'd0) begin miscompares++; $display("FAIL bp_ph0 got=%0d want=0", dout); end
    tick;
    wait_out(n);
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick;
      vectors += 3;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid c=%0d got=%b want=1", c, out_valid); end
      if (dout !== 16'd10000) begin miscompares++; $display("FAIL bp_hold_dout c=%0d got=%0d want=10000", c, dout); end
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_in_ready c=%0d got=%b want=0", c, in_ready); end
    end
    out_ready = 1'b1;
    tick;
    wait_out(n);
    vectors++;
    if (dout !== 16'd20000) begin miscompares++; $display("FAIL bp_ph2 got=%0d want=20000", dout); end
    tick;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_held_input got=%b want=1", in_ready); end
    tick;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_second_accept got=%b want=0", in_ready); end
    for (int ph = 0; ph < 3; ph++) begin
      wait_out(n);
      vectors++;
      if (dout !== 16'(b_exp[ph])) begin
        miscompares++;
        $display("FAIL bp_second[%0d] got=%0d want=%0d", ph, dout, b_exp[ph]);
      end
      tick;
    end
  endtask

  task automatic test_saturation;
    int n;
    int c_exp [3] = '{30000, 10000, 20000};
    do_reset;
    coef_we = 1'b1; coef_addr = 4'd3; coef_wdata = 16'd65535;
    tick;
    coef_addr = 4'd0; coef_wdata = 16'd32768;
    tick;
    coef_we = 1'b0;
    send(16'hFFFF);
    coef_we = 1'b1; coef_addr = 4'd1; coef_wdata = 16'd0;
    tick;
    coef_we = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      wait_out(n);
      if (ph == 0) begin
        vectors++;
        if (dout !== 16'hFFFF) begin miscompares++; $display("FAIL sat_first got=%h want=ffff", dout); end
      end
      tick;
    end
    send(16'hFFFF);
    for (int ph = 0; ph < 3; ph++) begin
      wait_out(n);
      if (ph == 0) begin
        vectors++;
        if (dout !== 16'hFFFF) begin miscompares++; $display("FAIL sat_clamp got=%h want=ffff", dout); end
      end
      tick;
    end
    for (int s = 0; s < 3; s++) begin
      send(16'd0);
      for (int ph = 0; ph < 3; ph++) begin wait_out(n); tick; end
    end
    n = 0;
    while (!in_ready && n < 100) begin tick; n++; end
    in_valid = 1'b1; din = 16'd30000;
    coef_we = 1'b1; coef_addr = 4'd2; coef_wdata = 16'd0;
    tick;
    in_valid = 1'b0; coef_we = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      wait_out(n);
      vectors++;
      if (dout !== 16'(c_exp[ph])) begin
        miscompares++;
        $display("FAIL coef_readback[%0d] got=%0d want=%0d", ph, dout, c_exp[ph]);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int imp [9] = '{0, 10000, 20000, 30000, 20000, 10000, 0, 0, 0};
    send(16'd30000);
    wait_out(n);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vectors += 4;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b want=0", busy); end
    if (dout !== 16'd0) begin miscompares++; $display("FAIL midrst_dout got=%0d want=0", dout); end
    for (int s = 0; s < 3; s++) begin
      send((s == 0) ? 16'd30000 : 16'd0);
      for (int ph = 0; ph < 3; ph++) begin
        wait_out(n);
        vectors++;
        if (dout !== 16'(imp[3*s+ph])) begin
          miscompares++;
          $display("FAIL midrst_impulse[%0d] got=%0d want=%0d", 3*s+ph, dout, imp[3*s+ph]);
        end
        tick;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; din = '0; in_valid = 1'b0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    test_reset;
    test_impulse;
    test_dc;
    test_backpressure;
    test_saturation;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
